// File: rtl/tod_event_sender.sv
// Time-of-day event generator: emits a latch event on Pps, then serialises the seconds word as bit events.
// Optional macro TOD_AUTOINC_EN makes the seconds counter self-increment on each Pps.
module tod_event_sender #(
  parameter int unsigned GAP       = 2,
  parameter logic [7:0]  EVT_ZERO  = 8'h70,
  parameter logic [7:0]  EVT_ONE   = 8'h71,
  parameter logic [7:0]  EVT_LATCH = 8'h7D
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic [7:0]  EventIn,
  input  logic        Pps,
  input  logic [31:0] SecondsIn,
  input  logic        SecondsLoad,
  output logic [7:0]  EventOut,
  output logic [31:0] Seconds,
  output logic        Busy,
  output logic        Overrun,
  output logic        Collision
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  localparam logic [3:0] GapInit  = 4'(GAP);
  localparam state_e     AfterBit = (GAP == 0) ? StShift : StGap;

  state_e      state_q, state_d;
  logic [4:0]  bitPtr_q, bitPtr_d;
  logic [3:0]  gapCnt_q, gapCnt_d;
  logic [7:0]  event_q, event_d;
  logic [31:0] seconds_q, seconds_d;
  logic [31:0] shadow_q, shadow_d;
  logic        overrun_q, overrun_d;
  logic        collision_q, collision_d;
  logic        isReserved;

  always_comb begin
    state_d     = state_q;
    bitPtr_d    = bitPtr_q;
    gapCnt_d    = gapCnt_q;
    event_d     = 8'h00;
    seconds_d   = seconds_q;
    shadow_d    = shadow_q;
    overrun_d   = 1'b0;
    collision_d = 1'b0;
    isReserved  = (EventIn == EVT_ZERO) || (EventIn == EVT_ONE) || (EventIn == EVT_LATCH);

`ifdef TOD_AUTOINC_EN
    if (SecondsLoad) begin
      seconds_d = SecondsIn;
    end else if (Pps) begin
      seconds_d = seconds_q + 32'd1;
    end
`else
    if (SecondsLoad) begin
      seconds_d = SecondsIn;
    end
`endif

    // The shadow word is frozen at Pps so later loads cannot disturb a transfer in flight.
    if (Pps) begin
      shadow_d    = seconds_d;
      event_d     = EVT_LATCH;
      collision_d = (EventIn != 8'h00);
      overrun_d   = (state_q != StIdle);
      bitPtr_d    = 5'd31;
      gapCnt_d    = GapInit;
      state_d     = AfterBit;
    end else if ((state_q == StShift) && (EventIn == 8'h00)) begin
      event_d = shadow_q[bitPtr_q] ? EVT_ONE : EVT_ZERO;
      if (bitPtr_q == 5'd0) begin
        bitPtr_d = 5'd31;
        gapCnt_d = 4'd0;
        state_d  = StIdle;
      end else begin
        bitPtr_d = bitPtr_q - 5'd1;
        gapCnt_d = GapInit;
        state_d  = AfterBit;
      end
    end else begin
      if (isReserved) begin
        collision_d = 1'b1;
      end else begin
        event_d = EventIn;
      end
      if (state_q == StGap) begin
        if (gapCnt_q <= 4'd1) begin
          gapCnt_d = 4'd0;
          state_d  = StShift;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q     <= StIdle;
      bitPtr_q    <= 5'd31;
      gapCnt_q    <= 4'd0;
      event_q     <= 8'h00;
      seconds_q   <= 32'd0;
      shadow_q    <= 32'd0;
      overrun_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitPtr_q    <= bitPtr_d;
      gapCnt_q    <= gapCnt_d;
      event_q     <= event_d;
      seconds_q   <= seconds_d;
      shadow_q    <= shadow_d;
      overrun_q   <= overrun_d;
      collision_q <= collision_d;
    end
  end

  assign EventOut  = event_q;
  assign Seconds   = seconds_q;
  assign Busy      = (state_q != StIdle);
  assign Overrun   = overrun_q;
  assign Collision = collision_q;

endmodule

// File: tb/tb_tod_event_sender.sv
// Randomised bench for tod_event_sender against a queue-and-timestamp model of the event merger.
module tb_tod_event_sender;

  localparam int unsigned GAP = 2;

  logic        Clock       = 1'b0;
  logic        ResetN      = 1'b0;
  logic [7:0]  EventIn     = 8'h00;
  logic        Pps         = 1'b0;
  logic [31:0] SecondsIn   = 32'd0;
  logic        SecondsLoad = 1'b0;
  logic [7:0]  EventOut;
  logic [31:0] Seconds;
  logic        Busy;
  logic        Overrun;
  logic        Collision;

  int testsRun    = 0;
  int testsFailed = 0;

  bit          pendingBits[$];
  longint      cycleNum    = 0;
  longint      nextAllowed = 0;
  logic [31:0] secModel    = 32'd0;
  logic [7:0]  expEvent    = 8'h00;
  logic        expBusy     = 1'b0;
  logic        expOverrun  = 1'b0;
  logic        expCollision = 1'b0;

  tod_event_sender #(.GAP(GAP)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .EventIn    (EventIn),
    .Pps        (Pps),
    .SecondsIn  (SecondsIn),
    .SecondsLoad(SecondsLoad),
    .EventOut   (EventOut),
    .Seconds    (Seconds),
    .Busy       (Busy),
    .Overrun    (Overrun),
    .Collision  (Collision)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cycleNum, observed, expected);
    end
  endtask

  function automatic bit reservedCode(input logic [7:0] e);
    return (e == 8'h70) || (e == 8'h71) || (e == 8'h7D);
  endfunction

  // One clock of the reference: a queue of bits still owed and the earliest cycle the next may go.
  task automatic modelStep();
    logic [31:0] newSec;
    cycleNum++;
    expOverrun   = 1'b0;
    expCollision = 1'b0;
    if (!ResetN) begin
      pendingBits.delete();
      secModel = 32'd0;
      expEvent = 8'h00;
    end else begin
      newSec = secModel;
`ifdef TOD_AUTOINC_EN
      if (Pps) newSec = secModel + 32'd1;
`endif
      if (SecondsLoad) newSec = SecondsIn;
      if (Pps) begin
        expEvent     = 8'h7D;
        expCollision = (EventIn != 8'h00);
        expOverrun   = (pendingBits.size() != 0);
        pendingBits.delete();
        for (int i = 31; i >= 0; i--) pendingBits.push_back(newSec[i]);
        nextAllowed = cycleNum + GAP + 1;
      end else if (pendingBits.size() != 0 && cycleNum >= nextAllowed && EventIn == 8'h00) begin
        expEvent    = pendingBits.pop_front() ? 8'h71 : 8'h70;
        nextAllowed = cycleNum + GAP + 1;
      end else if (reservedCode(EventIn)) begin
        expEvent     = 8'h00;
        expCollision = 1'b1;
      end else begin
        expEvent = EventIn;
      end
      secModel = newSec;
    end
    expBusy = (pendingBits.size() != 0);
  endtask

  task automatic applyStimulus(input logic rstN, input logic [7:0] ein, input logic pps,
                               input logic load, input logic [31:0] sin);
    @(negedge Clock);
    ResetN      = rstN;
    EventIn     = ein;
    Pps         = pps;
    SecondsLoad = load;
    SecondsIn   = sin;
    @(posedge Clock);
    modelStep();
    #1;
    checkOutput("EventOut", {24'd0, EventOut}, {24'd0, expEvent});
    checkOutput("Seconds", Seconds, secModel);
    checkOutput("Busy", {31'd0, Busy}, {31'd0, expBusy});
    checkOutput("Overrun", {31'd0, Overrun}, {31'd0, expOverrun});
    checkOutput("Collision", {31'd0, Collision}, {31'd0, expCollision});
  endtask

  task automatic runCycles(input int n, input bit interleave);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, (interleave && (i % 2 == 0)) ? 8'h2A : 8'h00, 1'b0, 1'b0, 32'd0);
    end
  endtask

  function automatic logic [7:0] randomEvent();
    int pick;
    pick = $urandom_range(0, 9);
    if (pick < 5) return 8'h00;
    if (pick == 5) begin
      case ($urandom_range(0, 2))
        0:       return 8'h70;
        1:       return 8'h71;
        default: return 8'h7D;
      endcase
    end
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'd0);

    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 32'h0000_0005);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 32'd0);
    runCycles(105, 1'b0);

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 32'd0);
    runCycles(200, 1'b1);

    applyStimulus(1'b1, 8'h2A, 1'b1, 1'b0, 32'd0);
    runCycles(31, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 32'd0);
    runCycles(105, 1'b0);

    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 32'd0);
    runCycles(105, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 32'h1234_5678);
    runCycles(20, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 32'hCAFE_0000);
    runCycles(90, 1'b0);

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 32'd0);
    runCycles(49, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'd0);
    runCycles(60, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    randomEvent(),
                    ($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 59) == 0),
                    $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
